// File: rtl/program_counter.sv
// Instruction-fetch program counter: steps by INCR each clock, or loads br_addr when branch is high.
// Latency: one cycle from branch/br_addr sample to pc_out; rst (active-low) clears asynchronously.
// Backpressure: none; there is no stall or enable, so the PC updates on every rising clk edge.
module program_counter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned INCR       = 1,
   parameter int unsigned RESET_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch,
   input  logic [WIDTH-1:0] br_addr,
   output logic [WIDTH-1:0] pc_out
);

   localparam logic [WIDTH-1:0] LP_INCR       = WIDTH'(INCR);
   localparam logic [WIDTH-1:0] LP_RESET_ADDR = WIDTH'(RESET_ADDR);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_next;

   // The sum wraps modulo 2^WIDTH by truncation; no overflow is reported.
   always_comb begin
      w_pc_next = r_pc + LP_INCR;
      if (branch) begin
         w_pc_next = br_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= LP_RESET_ADDR;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign pc_out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (WIDTH=8, INCR=1, RESET_ADDR=0, 10 ns clock).
module tb_program_counter;

   logic       clk;
   logic       rst;
   logic       branch;
   logic [7:0] br_addr;
   logic [7:0] pc_out;

   int n_tests = 0;
   int n_fail  = 0;

   program_counter #(
      .WIDTH      (8),
      .INCR       (1),
      .RESET_ADDR (0)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .branch  (branch),
      .br_addr (br_addr),
      .pc_out  (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge so outputs are sampled clear of it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b0;
      branch  = 1'b0;
      br_addr = 8'h00;

      // Reset held across two clock edges.
      #2;
      chk("reset_t2", pc_out, 8'h00);
      tick();
      chk("reset_edge1", pc_out, 8'h00);
      tick();
      chk("reset_edge2", pc_out, 8'h00);

      // Release and count ten edges.
      rst = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("count_%0d", i), pc_out, 8'(i));
      end

      // Asynchronous reset between edges, then resume.
      rst = 1'b0;
      #1;
      chk("async_reset", pc_out, 8'h00);
      tick();
      chk("reset_hold_edge", pc_out, 8'h00);
      rst = 1'b1;
      tick();
      chk("resume_1", pc_out, 8'h01);

      // br_addr has no effect without branch.
      br_addr = 8'h23;
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk($sformatf("ignore_br_%0d", i), pc_out, 8'(i));
      end
      branch = 1'b1;
      tick();
      chk("branch_23", pc_out, 8'h23);
      branch = 1'b0;
      br_addr = 8'h99;
      tick();
      chk("after_br_24", pc_out, 8'h24);
      tick();
      chk("after_br_25", pc_out, 8'h25);

      // Branch to the top address, then wrap.
      br_addr = 8'hFF;
      branch  = 1'b1;
      tick();
      chk("branch_ff", pc_out, 8'hFF);
      branch = 1'b0;
      tick();
      chk("wrap_00", pc_out, 8'h00);
      tick();
      chk("wrap_01", pc_out, 8'h01);

      // Branch during reset is lost; held branch reloads every edge.
      br_addr = 8'h40;
      branch  = 1'b1;
      rst     = 1'b0;
      #1;
      chk("br_in_reset", pc_out, 8'h00);
      tick();
      chk("br_in_reset_edge", pc_out, 8'h00);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("br_hold_%0d", i), pc_out, 8'h40);
      end
      branch = 1'b0;
      tick();
      chk("br_release_41", pc_out, 8'h41);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
